// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and decode-side handshake bundle for fetch_unit.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, Instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, Instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, single-outstanding imem handshake and prefetch FIFO.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_flushes/perf_starve counters.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus,
  input  logic         PCSrc,
  input  logic [31:0]  redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_flushes,
  output logic [31:0]  perf_starve
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   word_q [DEPTH];
  logic [31:0]   word_d [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   imem_addr_q, imem_addr_d;
  logic          imem_req_q, imem_req_d;
  logic          discard_q, discard_d;

  logic ack, push, pop, hold, instr_valid;

  always_comb begin
    instr_valid = (count_q != '0);
    ack         = imem_req_q & bus.imem_ack;
    // A redirect wins over both FIFO ports in the same cycle.
    push        = ack & ~discard_q & ~PCSrc;
    pop         = instr_valid & bus.instr_ready & ~PCSrc;
    hold        = imem_req_q & ~bus.imem_ack;

    word_d   = word_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      word_d[wr_ptr_q] = bus.imem_rdata;
      pc_d[wr_ptr_q]   = imem_addr_q;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (PCSrc) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      discard_d  = hold;
    end else begin
      if (push) fetch_pc_d = imem_addr_q + 32'd4;
      if (ack)  discard_d  = 1'b0;
    end

    // An un-acked request is held unchanged, even across a redirect.
    if (hold) begin
      imem_req_d  = 1'b1;
      imem_addr_d = imem_addr_q;
    end else begin
      imem_req_d  = (count_d < DEPTH_C);
      imem_addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      fetch_pc_q  <= RESET_PC;
      imem_addr_q <= RESET_PC;
      imem_req_q  <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_addr_q <= imem_addr_d;
      imem_req_q  <= imem_req_d;
      discard_q   <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
    pc_q   <= pc_d;
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = instr_valid;
  assign bus.Instr       = instr_valid ? word_q[rd_ptr_q] : 32'd0;
  assign bus.instr_pc    = instr_valid ? pc_q[rd_ptr_q] : 32'd0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;
  logic [31:0] perf_starve_q, perf_starve_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(push);
    perf_flushes_d = perf_flushes_q + 32'(PCSrc);
    perf_starve_d  = perf_starve_q + 32'(~instr_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
      perf_starve_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushes_q <= perf_flushes_d;
      perf_starve_q  <= perf_starve_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
  assign perf_starve  = perf_starve_q;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the controller/datapath. It owns the fetch PC, runs a single-outstanding request/acknowledge handshake to instruction memory, and buffers returned words in a small prefetch FIFO. It presents `Instr` plus its address to decode with a valid/ready handshake, and flushes and refetches when the controller asserts `PCSrc`.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, 2..16.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  fetch request; registered.
- `imem_addr`  out  32  word address of the request; registered; bits [1:0] always 0.
- `imem_ack`  in  1  memory accepts the request and returns data this cycle.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack`=1.
- `PCSrc`  in  1  redirect request from the controller.
- `redirect_pc`  in  32  target address; bits [1:0] ignored (forced to 0).
- `instr_ready`  in  1  decode consumes the head entry this cycle.
- `instr_valid`  out  1  FIFO non-empty.
- `Instr`  out  32  head entry instruction word.
- `instr_pc`  out  32  head entry fetch address.

## Operation
- State: `fetch_pc`, `outstanding`, `discard`, and a FIFO of {word, pc} with read/write pointers and `count`.
- Request: `imem_req`/`imem_addr` hold steady from assertion until the cycle `imem_ack`=1. A request is never withdrawn or altered, including across a redirect.
- Issue rule: next cycle `imem_req`=1 iff (count_next + 1) <= DEPTH and reset is low. count_next includes this cycle's push and pop.
- Ack without discard: push {`imem_rdata`, `imem_addr`} and set `fetch_pc` = `imem_addr`+4, wrapping mod 2^32.
- Ack with `discard`=1: drop the data and clear `discard`. The next request uses the redirect target.
- Pop: occurs when `instr_valid` && `instr_ready`. Simultaneous push and pop leave `count` unchanged; push into a full FIFO cannot occur by construction.
- Redirect (`PCSrc`=1): takes priority over push and pop in the same cycle.
  - FIFO is emptied, so `count`=0 and `instr_valid`=0 next cycle.
  - `fetch_pc` is set to {redirect_pc[31:2],2'b00}.
  - If a request is outstanding and not acked this cycle, `discard`=1.
  - If it is acked this cycle, its data is dropped.
- Back-to-back redirects: the latest target wins. `discard` stays set until the pending ack is received.
- Reset: FIFO emptied, `count`=0, `outstanding`=0, `discard`=0, `fetch_pc`=RESET_PC.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `Instr`=0, `instr_pc`=0.
- First `imem_req`=1 appears the cycle after `reset` deasserts.
- Latency: ack in cycle N puts the word at the FIFO head with `instr_valid`=1 in cycle N+1 (FIFO was empty).
- Throughput: one instruction per cycle with zero-wait memory (ack every cycle) and `instr_ready`=1.
- Redirect latency: `PCSrc` in cycle N gives `imem_addr`=target no earlier than cycle N+1. The first target instruction is valid one cycle after its ack.
- `Instr`/`instr_pc` are stable while `instr_valid`=1 and `instr_ready`=0.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds three outputs:
  - `perf_fetched` (32): count of acks not discarded.
  - `perf_flushes` (32): count of cycles with `PCSrc`=1.
  - `perf_starve` (32): count of cycles with `instr_valid`=0 and `reset`=0.
  - All three wrap mod 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Zero-wait stream: reset low at cycle 0, ack every cycle, `instr_ready`=1 -> `instr_pc` = 0,4,8,C on consecutive cycles from cycle 2.
- Backpressure: `instr_ready`=0 with DEPTH=4 -> exactly 4 acks accepted, then `imem_req`=0. Raising ready for 1 cycle pops `instr_pc`=0 and issues one request for addr 0x10.
- Redirect with ack pending: req addr 0x8 outstanding, `PCSrc`=1 with `redirect_pc`=0x103, ack 3 cycles later -> that word is dropped and the next `imem_addr`=0x100. The first valid `instr_pc`=0x100.
- Redirect coinciding with push and pop: FIFO holds 2 entries, ack, pop and `PCSrc` in the same cycle -> `instr_valid`=0 next cycle and `count`=0.
- Wrap-around: `redirect_pc`=0xFFFF_FFFC -> the following fetch addr is 0x0000_0000.
- Reset mid-operation: `reset`=1 with FIFO full and a request outstanding -> next cycle `imem_req`=0 and `instr_valid`=0. After release, `imem_addr`=RESET_PC. With `FETCH_PERF_CNT_EN`, all counters read 0.
